multi_ch_fifo: RTL

- Single-clock FIFO holding NUM_CH independent queues in one shared storage array. Each queue has DEPTH entries.
- Writer and reader each select a queue by channel index every cycle.
- Each channel exposes full, empty, almost-full, almost-empty, occupancy count and sticky overflow/underflow flags.
- Successor to the dual-clock single-queue FIFO, for per-channel buffering in synchronous datapaths (e.g. per-port ingress queues).

---
 rtl/multi_ch_fifo.sv | 122 ++++++++++++
 1 files changed

// File: rtl/multi_ch_fifo.sv
// Single-clock FIFO holding NUM_CH independent queues in one shared storage array.
// Flags decode from registered per-channel counts; read data is registered or combinational per RD_BUFFER.
module multi_ch_fifo #(
   parameter int unsigned DEPTH           = 16,
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned NUM_CH          = 4,
   parameter int unsigned RD_BUFFER       = 1,
   parameter int unsigned ALMOST_FULL_TH  = 14,
   parameter int unsigned ALMOST_EMPTY_TH = 2,
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [CH_W-1:0]         wr_ch,
   input  logic [DATA_WIDTH-1:0]   data_wr,
   input  logic                    rd_en,
   input  logic [CH_W-1:0]         rd_ch,
   output logic [DATA_WIDTH-1:0]   data_rd,
   output logic                    rd_valid,
   output logic [NUM_CH-1:0]       fifo_full,
   output logic [NUM_CH-1:0]       fifo_empty,
   output logic [NUM_CH-1:0]       almost_full,
   output logic [NUM_CH-1:0]       almost_empty,
   output logic [NUM_CH*CNT_W-1:0] count,
   input  logic                    err_clr,
   output logic [NUM_CH-1:0]       overflow,
   output logic [NUM_CH-1:0]       underflow
);

   localparam int unsigned ADDR_W = $clog2(NUM_CH * DEPTH);

   logic [DATA_WIDTH-1:0] mem    [NUM_CH*DEPTH];
   logic [PTR_W-1:0]      wr_ptr [NUM_CH];
   logic [PTR_W-1:0]      rd_ptr [NUM_CH];
   logic [CNT_W-1:0]      cnt    [NUM_CH];

   logic [NUM_CH-1:0] wr_sel, rd_sel, wr_acc, rd_acc;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic              wr_any, rd_any;

   // Wrapping increment that also handles non-power-of-two depths.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Flag decode, request steering and address selection; out-of-range channels match nothing.
   always_comb begin
      fifo_full    = '0;
      fifo_empty   = '0;
      almost_full  = '0;
      almost_empty = '0;
      count        = '0;
      wr_sel       = '0;
      rd_sel       = '0;
      wr_acc       = '0;
      rd_acc       = '0;
      wr_addr      = '0;
      rd_addr      = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         fifo_full[c]              = (cnt[c] == CNT_W'(DEPTH));
         fifo_empty[c]             = (cnt[c] == '0);
         almost_full[c]            = (32'(cnt[c]) >= ALMOST_FULL_TH);
         almost_empty[c]           = (32'(cnt[c]) <= ALMOST_EMPTY_TH);
         count[c*CNT_W +: CNT_W]   = cnt[c];
         wr_sel[c]                 = wr_en && (wr_ch == CH_W'(c));
         rd_sel[c]                 = rd_en && (rd_ch == CH_W'(c));
         wr_acc[c]                 = wr_sel[c] && !fifo_full[c];
         rd_acc[c]                 = rd_sel[c] && !fifo_empty[c];
         if (wr_sel[c]) wr_addr = ADDR_W'(c * DEPTH) + ADDR_W'(wr_ptr[c]);
         if (rd_sel[c]) rd_addr = ADDR_W'(c * DEPTH) + ADDR_W'(rd_ptr[c]);
      end
      wr_any = |wr_acc;
      rd_any = |rd_acc;
   end

   always_ff @(posedge clk) begin
      if (wr_any) mem[wr_addr] <= data_wr;
   end

   // Per-channel pointers, counts and sticky error bits; a set event beats err_clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
            cnt[c]    <= '0;
         end
         overflow  <= '0;
         underflow <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (wr_acc[c]) wr_ptr[c] <= ptr_inc(wr_ptr[c]);
            if (rd_acc[c]) rd_ptr[c] <= ptr_inc(rd_ptr[c]);
            if (wr_acc[c] && !rd_acc[c])      cnt[c] <= cnt[c] + CNT_W'(1);
            else if (rd_acc[c] && !wr_acc[c]) cnt[c] <= cnt[c] - CNT_W'(1);
         end
         overflow  <= (overflow  & {NUM_CH{!err_clr}}) | (wr_sel & fifo_full);
         underflow <= (underflow & {NUM_CH{!err_clr}}) | (rd_sel & fifo_empty);
      end
   end

   if (RD_BUFFER != 0) begin : g_rd_reg
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data_rd  <= '0;
            rd_valid <= 1'b0;
         end else begin
            rd_valid <= rd_any;
            if (rd_any) data_rd <= mem[rd_addr];
         end
      end
   end else begin : g_rd_comb
      always_comb begin
         data_rd  = rd_any ? mem[rd_addr] : '0;
         rd_valid = rd_any;
      end
   end

endmodule
